// File: rtl/coin_dispenser_if.sv
// Handshake and status bundle between coffee_machine and the coin dispenser.
interface coin_dispenser_if;
   localparam int unsigned AMT_W  = 16;
   localparam int unsigned COIN_W = 8;

   logic              tick;
   logic              start;
   logic [AMT_W-1:0]  amount;
   logic              eject;
   logic              busy;
   logic              done;
   logic              err;
   logic [AMT_W-1:0]  remaining;
   logic [COIN_W-1:0] coin_count;

   // Requester side: issues requests and timing ticks, observes progress.
   modport master (
      output tick,
      output start,
      output amount,
      input  eject,
      input  busy,
      input  done,
      input  err,
      input  remaining,
      input  coin_count
   );

   // Dispenser side.
   modport slave (
      input  tick,
      input  start,
      input  amount,
      output eject,
      output busy,
      output done,
      output err,
      output remaining,
      output coin_count
   );
endinterface

// File: rtl/coin_dispenser.sv
// Change-return back end: turns a won amount into a timed train of solenoid
// eject pulses, one per coin, paced by the 1 kHz tick.
module coin_dispenser #(
   parameter int unsigned COIN_VALUE = 100,
   parameter int unsigned PULSE_MS   = 50,
   parameter int unsigned GAP_MS     = 150,
   parameter int unsigned MAX_AMOUNT = 9900
) (
   input logic             clk,
   input logic             reset,
   coin_dispenser_if.slave bus
);

   localparam int unsigned AMT_W   = 16;
   localparam int unsigned COIN_W  = 8;
   localparam int unsigned CNT_MAX = (PULSE_MS > GAP_MS) ? PULSE_MS : GAP_MS;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EJECT_ON  = 2'd1,
      EJECT_GAP = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [AMT_W-1:0]    remaining_q;
   logic [AMT_W-1:0]    remaining_d;
   logic [COIN_W-1:0]   coin_count_q;
   logic [COIN_W-1:0]   coin_count_d;
   logic                err_d;
   logic                eject_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   logic                amount_bad_c;
   logic                pulse_end_c;
   logic                gap_end_c;

   // Request is rejected when too large or not a whole number of coins.
   assign amount_bad_c = (bus.amount > AMT_W'(MAX_AMOUNT)) ||
                         ((bus.amount % AMT_W'(COIN_VALUE)) != '0);

   // Last tick of the high window and of the low window respectively.
   assign pulse_end_c = bus.tick && (cnt_q == CNT_W'(PULSE_MS - 1));
   assign gap_end_c   = bus.tick && (cnt_q == CNT_W'(GAP_MS - 1));

   // Next-state, tick counter and datapath updates.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      remaining_d  = remaining_q;
      coin_count_d = coin_count_q;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            // Ticks seen while idle (including one coincident with start) are not counted.
            cnt_d = '0;
            if (bus.start) begin
               if (amount_bad_c) begin
                  err_d = 1'b1;
               end else if (bus.amount == '0) begin
                  // A zero request is a valid dispense of no coins.
                  remaining_d  = '0;
                  coin_count_d = '0;
                  state_d      = DONE;
               end else begin
                  remaining_d  = bus.amount;
                  coin_count_d = '0;
                  state_d      = EJECT_ON;
               end
            end
         end

         EJECT_ON: begin
            if (pulse_end_c) begin
               cnt_d        = '0;
               remaining_d  = remaining_q - AMT_W'(COIN_VALUE);
               coin_count_d = coin_count_q + COIN_W'(1);
               state_d      = EJECT_GAP;
            end else if (bus.tick) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         EJECT_GAP: begin
            if (gap_end_c) begin
               cnt_d   = '0;
               state_d = (remaining_q == '0) ? DONE : EJECT_ON;
            end else if (bus.tick) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered output decodes of the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         remaining_q  <= '0;
         coin_count_q <= '0;
         eject_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         remaining_q  <= remaining_d;
         coin_count_q <= coin_count_d;
         eject_q      <= (state_d == EJECT_ON);
         busy_q       <= (state_d == EJECT_ON) || (state_d == EJECT_GAP);
         done_q       <= (state_d == DONE);
         err_q        <= err_d;
      end
   end

   assign bus.eject      = eject_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.remaining  = remaining_q;
   assign bus.coin_count = coin_count_q;

   // done and err are mutually exclusive pulses.
   assert property (@(posedge clk) disable iff (reset) !(done_q && err_q));

   // The solenoid is only driven while in the high window.
   assert property (@(posedge clk) disable iff (reset) eject_q |-> (state_q == EJECT_ON));

endmodule

// File: tb/tb_coin_dispenser.sv
// Randomized self-checking bench for coin_dispenser with a tick-indexed reference model.
module tb_coin_dispenser;

   localparam int P    = 2;
   localparam int G    = 3;
   localparam int COIN = 100;
   localparam int MAXA = 9900;

   logic clk = 1'b0;
   logic reset;

   coin_dispenser_if dif();

   coin_dispenser #(
      .COIN_VALUE (COIN),
      .PULSE_MS   (P),
      .GAP_MS     (G),
      .MAX_AMOUNT (MAXA)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // One tick every 10 clocks, changed shortly after the rising edge.
   int tdiv = 0;
   always @(posedge clk) begin
      #2;
      tdiv    = (tdiv == 9) ? 0 : tdiv + 1;
      dif.tick = (tdiv == 9);
   end

   // Reference model: a dispense of n coins is described by k, the number of
   // ticks seen since the accepted start. Coin i is high for k in
   // [i*(P+G), i*(P+G)+P) and the dispense ends when k reaches n*(P+G).
   bit m_active = 0, m_done = 0, m_err = 0, m_eject = 0, m_busy = 0;
   int m_k = 0, m_n = 0, m_base = 0, m_rem = 0, m_cnt = 0;

   always @(posedge clk) begin
      bit was_done;
      int fin;
      was_done = m_done;
      m_done   = 1'b0;
      m_err    = 1'b0;
      if (reset) begin
         m_active = 1'b0;
         m_k      = 0;
         m_rem    = 0;
         m_cnt    = 0;
      end else if (m_active) begin
         if (dif.tick) m_k++;
         fin = (m_k >= P) ? (m_k - P) / (P + G) + 1 : 0;
         if (fin > m_n) fin = m_n;
         m_cnt = fin;
         m_rem = m_base - COIN * fin;
         if (m_k == m_n * (P + G)) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end else if (!was_done && dif.start) begin
         if (int'(dif.amount) > MAXA || (int'(dif.amount) % COIN) != 0) begin
            m_err = 1'b1;
         end else if (dif.amount == 16'd0) begin
            m_done = 1'b1;
            m_cnt  = 0;
            m_rem  = 0;
         end else begin
            m_active = 1'b1;
            m_base   = int'(dif.amount);
            m_n      = m_base / COIN;
            m_k      = 0;
            m_cnt    = 0;
            m_rem    = m_base;
         end
      end
      m_eject = m_active && ((m_k % (P + G)) < P);
      m_busy  = m_active;
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("eject", int'(dif.eject), int'(m_eject));
         chk("busy", int'(dif.busy), int'(m_busy));
         chk("done", int'(dif.done), int'(m_done));
         chk("err", int'(dif.err), int'(m_err));
         chk("remaining", int'(dif.remaining), m_rem);
         chk("coin_count", int'(dif.coin_count), m_cnt);
      end
   end

   // Observed pulse statistics for the directed literal checks.
   int rises = 0, dones = 0, hi_len = 0, last_hi = 0;
   bit ej_prev = 1'b0;
   always @(negedge clk) begin
      if (dif.eject && !ej_prev) begin
         rises++;
         hi_len = 0;
      end
      if (dif.eject) hi_len++;
      if (!dif.eject && ej_prev) last_hi = hi_len;
      if (dif.done) dones++;
      ej_prev = dif.eject;
   end

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic pulse_start(input int a);
      dif.start  = 1'b1;
      dif.amount = 16'(a);
      step();
      dif.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_active || m_done) && n < 20000) begin
         step();
         n++;
      end
      if (n >= 20000) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic wait_tick_cycle();
      int n = 0;
      while (!dif.tick && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk("tick_wait_timeout", 1, 0);
   endtask

   function automatic int rand_amount();
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
         0, 1, 2, 3, 4, 5: return COIN * int'($urandom_range(1, 6));
         6:                return 0;
         7:                return int'($urandom_range(0, 65535));
         8:                return COIN * int'($urandom_range(0, 5)) + int'($urandom_range(1, 99));
         default:          return COIN * int'($urandom_range(99, 110));
      endcase
   endfunction

   initial begin
      int r0, d0;
      reset      = 1'b1;
      dif.start  = 1'b1;
      dif.amount = 16'd300;

      // Reset held with a start request pending: everything stays quiet.
      step();
      chk_on = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_eject", int'(dif.eject), 0);
         chk("rst_busy", int'(dif.busy), 0);
      end
      reset     = 1'b0;
      dif.start = 1'b0;
      step();
      chk("rst_fall_eject", int'(dif.eject), 0);
      step();

      // 300 won: three coins, countdown 300..0.
      r0 = rises; d0 = dones;
      pulse_start(300);
      chk("d300_rem_first", int'(dif.remaining), 300);
      chk("d300_busy_first", int'(dif.busy), 1);
      wait_idle();
      chk("d300_pulses", rises - r0, 3);
      chk("d300_count", int'(dif.coin_count), 3);
      chk("d300_rem_end", int'(dif.remaining), 0);
      chk("d300_dones", dones - d0, 1);
      step();

      // Rejected and zero requests.
      r0 = rises; d0 = dones;
      pulse_start(250);
      chk("e250_err", int'(dif.err), 1);
      chk("e250_busy", int'(dif.busy), 0);
      step();
      pulse_start(10000);
      chk("e10000_err", int'(dif.err), 1);
      step();
      pulse_start(9901);
      chk("e9901_err", int'(dif.err), 1);
      step();
      pulse_start(0);
      chk("z0_done", int'(dif.done), 1);
      chk("z0_err", int'(dif.err), 0);
      step();
      step();
      chk("rej_no_eject", rises - r0, 0);
      chk("z0_single_done", dones - d0, 1);

      // Second request during the first gap is ignored.
      r0 = rises;
      pulse_start(200);
      begin
         int n = 0;
         while (!(m_active && m_cnt == 1 && !m_eject) && n < 200) begin step(); n++; end
         if (n >= 200) chk("gap_wait_timeout", 1, 0);
      end
      pulse_start(500);
      wait_idle();
      chk("ign_pulses", rises - r0, 2);
      chk("ign_rem", int'(dif.remaining), 0);
      chk("ign_count", int'(dif.coin_count), 2);
      step();

      // Reset during the second high window of a 500 won dispense.
      d0 = dones;
      pulse_start(500);
      begin
         int n = 0;
         while (!(m_cnt == 1 && m_eject) && n < 200) begin step(); n++; end
         if (n >= 200) chk("on2_wait_timeout", 1, 0);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_eject", int'(dif.eject), 0);
      chk("mid_rst_rem", int'(dif.remaining), 0);
      step();
      step();
      chk("mid_rst_no_done", dones - d0, 0);
      r0 = rises; d0 = dones;
      pulse_start(100);
      wait_idle();
      chk("after_rst_pulses", rises - r0, 1);
      chk("after_rst_done", dones - d0, 1);
      step();

      // Start coincident with a tick: high window is exactly two full tick periods.
      wait_tick_cycle();
      pulse_start(100);
      wait_idle();
      chk("tick_coinc_hi_len", last_hi, 20);

      // Largest accepted amount.
      step();
      pulse_start(9900);
      wait_idle();
      chk("max_count", int'(dif.coin_count), 99);

      // Randomized traffic, including starts while busy and occasional resets.
      for (int c = 0; c < 9000; c++) begin
         dif.start  = 1'b0;
         reset      = 1'b0;
         dif.amount = 16'(rand_amount());
         if ($urandom_range(0, 1999) == 0) reset = 1'b1;
         else if (!m_busy && $urandom_range(0, 7) == 0) dif.start = 1'b1;
         else if (m_busy && $urandom_range(0, 49) == 0) dif.start = 1'b1;
         step();
      end
      dif.start = 1'b0;
      reset     = 1'b0;
      wait_idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
